mod_add_reduce: RTL
===================

MOD_ADD_REDUCE -- requirements
Module: mod_add_reduce

Interface
REQ-001 SHALL have parameter OP_W, default 384, operand width in bits.
REQ-002 SHALL have parameter LIMB_W, default 64, subtraction limb width; OP_W SHALL be an integer multiple of LIMB_W.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to reduce the presented operands.
REQ-006 SHALL have port inC, input, OP_W+1, unreduced sum from the upstream adder's outC.
REQ-007 SHALL have port inM, input, OP_W, modulus M.
REQ-008 SHALL have port busy, output, 1, high from operand capture until done.
REQ-009 SHALL have port result, output, OP_W, reduced value.
REQ-010 SHALL have port done, output, 1, one-cycle pulse marking result valid.

Function
REQ-011 SHALL compute result = (inC >= M) ? inC - M : inC[OP_W-1:0], as a single conditional subtraction; correctness modulo M holds only for inC < 2M.
REQ-012 SHALL use FSM states IDLE, SUB and FIN.
REQ-013 IDLE: start=1 at a clock edge SHALL capture inC and inM into internal registers, clear limb counter and borrow, set busy, and enter SUB.
REQ-014 SUB: each cycle SHALL subtract limb i of M plus borrow from limb i of captured C, store the difference limb, update borrow, and increment the counter.
REQ-015 SUB SHALL iterate limbs 0..N-1, N = OP_W/LIMB_W (6 by default), LSB limb first, then enter FIN.
REQ-016 FIN: if C[OP_W]=1 or final borrow=0, result SHALL take the difference; otherwise result SHALL take captured C[OP_W-1:0].
REQ-017 FIN SHALL assert done for exactly one cycle, clear busy, and return to IDLE.
REQ-018 Latency SHALL be N+1 edges: start sampled at edge 0 makes done high after edge N+1 (edge 7 by default).
REQ-019 start while busy=1 SHALL be ignored; captured operands SHALL be unaffected.
REQ-020 start asserted during the done cycle SHALL be accepted at the next edge, giving back-to-back throughput of one result per N+2 cycles.
REQ-021 result SHALL hold its value from done until the next done.
REQ-022 inM=0 SHALL yield result = inC[OP_W-1:0].
REQ-023 inC >= 2M SHALL still yield exactly one subtraction, with no error flag.

Reset
REQ-024 resetn=0 SHALL immediately force state IDLE and set busy=0, done=0 and result=0, and SHALL clear the counter, borrow and captured registers.
REQ-025 Reset asserted mid-SUB or in FIN SHALL abort the operation with no done pulse; the first start after resetn rises SHALL begin a fresh operation.

Structure
REQ-026 A shared package SHALL hold OP_W, LIMB_W, N_LIMBS and the FSM state encoding.
REQ-027 The limb subtract-with-borrow SHALL be a sub-module named mod_sub_limb (LIMB_W-bit a, b, bin -> diff, bout), instantiated once and time-multiplexed.

Verification
REQ-028 Bench SHALL cover: inC=0x7, M=0x5 -> result 0x2, done high after exactly 7 edges from start sample.
REQ-029 Bench SHALL cover: inC=0x5, M=0x5 -> result 0x0; and inC=0x4, M=0x5 -> result 0x4 (borrow-out path).
REQ-030 Bench SHALL cover: inC=2^64, M=0x1 -> result 0xFFFFFFFFFFFFFFFF (borrow ripples across the limb boundary).
REQ-031 Bench SHALL cover: inC=2^384 (bit 384 set only), M=all-ones 384 bits -> result 0x1 (top-bit select path).
REQ-032 Bench SHALL cover: start held high continuously with two operand sets -> the second is accepted the edge after the first done, busy ignores start mid-operation, and both results are correct.
REQ-033 Bench SHALL cover: resetn pulsed low in cycle 3 of SUB -> outputs 0 immediately, no done pulse; a subsequent start with inC=0x7, M=0x5 -> result 0x2.

Source files
------------

// File: rtl/mod_add_reduce_pkg.sv
// Shared widths and FSM encoding for the modular add reducer.
package mod_add_reduce_pkg;

    localparam int OP_W    = 384;
    localparam int LIMB_W  = 64;
    localparam int N_LIMBS = OP_W / LIMB_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/mod_sub_limb.sv
// One limb of a ripple subtractor: diff = a - b - bin, bout set on underflow.
module mod_sub_limb #(
    parameter int LIMB_W = 64
) (
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              bin,
    output logic [LIMB_W-1:0] diff,
    output logic              bout
);

    assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{LIMB_W{1'b0}}, bin};

endmodule

// File: rtl/mod_add_reduce.sv
// Conditional subtraction of M from an (OP_W+1)-bit sum, one limb per cycle.
// Handshake: start is sampled only while idle (busy=0); done pulses for one
// cycle with result valid, and result holds until the next done.
module mod_add_reduce #(
    parameter int OP_W   = mod_add_reduce_pkg::OP_W,
    parameter int LIMB_W = mod_add_reduce_pkg::LIMB_W
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [OP_W:0]             inC,
    input  logic [OP_W-1:0]           inM,
    output logic                      busy,
    output logic [OP_W-1:0]           result,
    output logic                      done,
    output mod_add_reduce_pkg::state_t o_dbg_state
);

    import mod_add_reduce_pkg::state_t;
    import mod_add_reduce_pkg::IDLE;
    import mod_add_reduce_pkg::SUB;
    import mod_add_reduce_pkg::FIN;

    localparam int N     = OP_W / LIMB_W;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t            r_state;
    logic              r_c_top;
    logic [OP_W-1:0]   r_c;
    logic [OP_W-1:0]   r_m;
    logic [OP_W-1:0]   r_diff;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_borrow;
    logic [OP_W-1:0]   r_result;
    logic              r_busy;
    logic              r_done;

    logic [LIMB_W-1:0] w_diff;
    logic              w_bout;

    // C and M rotate by one limb per SUB cycle, so after N cycles both are
    // back in their captured positions for the final select.
    mod_sub_limb #(.LIMB_W(LIMB_W)) u_sub (
        .a    (r_c[LIMB_W-1:0]),
        .b    (r_m[LIMB_W-1:0]),
        .bin  (r_borrow),
        .diff (w_diff),
        .bout (w_bout)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_c_top  <= 1'b0;
            r_c      <= '0;
            r_m      <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_c_top  <= inC[OP_W];
                        r_c      <= inC[OP_W-1:0];
                        r_m      <= inM;
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= SUB;
                    end
                end
                SUB: begin
                    r_c      <= {r_c[LIMB_W-1:0], r_c[OP_W-1:LIMB_W]};
                    r_m      <= {r_m[LIMB_W-1:0], r_m[OP_W-1:LIMB_W]};
                    r_diff   <= {w_diff, r_diff[OP_W-1:LIMB_W]};
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    // A set carry bit means C >= 2^OP_W > M regardless of borrow.
                    r_result <= (r_c_top || !r_borrow) ? r_diff : r_c;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign result      = r_result;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule
